// File: rtl/llc_mem_bridge_pkg.sv
// rtl/llc_mem_bridge_pkg.sv - shared cache line types, widths and memory command struct
package llc_mem_bridge_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int BITS_PER_WORD  = 64;
  localparam int ADDR_BITS      = 32;
  localparam int LINE_BITS      = WORDS_PER_LINE * BITS_PER_WORD;
  localparam int LINE_BYTES     = LINE_BITS / 8;
  localparam int OFFSET_BITS    = $clog2(LINE_BYTES);
  localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int CNT_BITS       = $clog2(WORDS_PER_LINE);

  typedef logic [BITS_PER_WORD-1:0]                      word_t;
  typedef logic [WORDS_PER_LINE-1:0][BITS_PER_WORD-1:0]  line_t;
  typedef logic [LINE_ADDR_BITS-1:0]                     line_addr_t;
  typedef logic [ADDR_BITS-1:0]                          addr_t;
  typedef logic [CNT_BITS-1:0]                           cnt_t;
  typedef logic [2:0]                                    hsize_t;
  typedef logic [1:0]                                    hprot_t;

  localparam cnt_t LAST_IDX = cnt_t'(WORDS_PER_LINE - 1);

  typedef struct packed {
    logic   write;
    addr_t  addr;
    cnt_t   len;
    hsize_t size;
    hprot_t prot;
  } mem_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_WDATA, ST_WACK, ST_RDATA, ST_RSP
  } state_t;

  function automatic addr_t line_to_byte_addr(input line_addr_t a);
    return {a, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/llc_mem_bridge_if.sv
// rtl/llc_mem_bridge_if.sv - LLC line channel and word-wide memory beat bus interfaces
interface llc_mem_if;
  import llc_mem_bridge_pkg::*;

  logic       llc_mem_req_valid;
  logic       llc_mem_req_ready;
  logic       llc_mem_req_data_hwrite;
  hsize_t     llc_mem_req_data_hsize;
  hprot_t     llc_mem_req_data_hprot;
  line_addr_t llc_mem_req_data_addr;
  line_t      llc_mem_req_data_line;
  logic       llc_mem_rsp_valid;
  logic       llc_mem_rsp_ready;
  line_t      llc_mem_rsp_data_line;

  modport master (
    output llc_mem_req_valid, llc_mem_req_data_hwrite, llc_mem_req_data_hsize,
           llc_mem_req_data_hprot, llc_mem_req_data_addr, llc_mem_req_data_line,
           llc_mem_rsp_ready,
    input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_data_line
  );

  modport slave (
    input  llc_mem_req_valid, llc_mem_req_data_hwrite, llc_mem_req_data_hsize,
           llc_mem_req_data_hprot, llc_mem_req_data_addr, llc_mem_req_data_line,
           llc_mem_rsp_ready,
    output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_data_line
  );
endinterface

interface mem_beat_if;
  import llc_mem_bridge_pkg::*;

  logic   mem_cmd_valid;
  logic   mem_cmd_ready;
  logic   mem_cmd_write;
  addr_t  mem_cmd_addr;
  cnt_t   mem_cmd_len;
  hsize_t mem_cmd_size;
  hprot_t mem_cmd_prot;
  logic   mem_wdata_valid;
  logic   mem_wdata_ready;
  word_t  mem_wdata;
  logic   mem_wlast;
  logic   mem_wack_valid;
  logic   mem_rdata_valid;
  logic   mem_rdata_ready;
  word_t  mem_rdata;
  logic   mem_rlast;

  modport master (
    output mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len, mem_cmd_size,
           mem_cmd_prot, mem_wdata_valid, mem_wdata, mem_wlast, mem_rdata_ready,
    input  mem_cmd_ready, mem_wdata_ready, mem_wack_valid, mem_rdata_valid,
           mem_rdata, mem_rlast
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len, mem_cmd_size,
           mem_cmd_prot, mem_wdata_valid, mem_wdata, mem_wlast, mem_rdata_ready,
    output mem_cmd_ready, mem_wdata_ready, mem_wack_valid, mem_rdata_valid,
           mem_rdata, mem_rlast
  );
endinterface

// File: rtl/llc_mem_line_buf.sv
// rtl/llc_mem_line_buf.sv - line register with whole-line load, clear and indexed word access
module llc_mem_line_buf
  import llc_mem_bridge_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  line_t load_line,
  input  logic  clr,
  input  logic  wr_en,
  input  cnt_t  wr_idx,
  input  word_t wr_word,
  input  cnt_t  rd_idx,
  output word_t rd_word,
  output line_t line
);

  line_t line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_line;
    end else if (clr) begin
      line_q <= '0;
    end else if (wr_en) begin
      line_q[wr_idx] <= wr_word;
    end
  end

  assign rd_word = line_q[rd_idx];
  assign line    = line_q;

endmodule

// File: rtl/llc_mem_bridge.sv
// rtl/llc_mem_bridge.sv - converts whole-line LLC requests into word bursts and reassembles fills
module llc_mem_bridge
  import llc_mem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  llc_mem_if.slave    llc,
  mem_beat_if.master  mem,
  output logic        err_sticky
);

  state_t   state_q, state_d;
  cnt_t     cnt_q;
  mem_cmd_t cmd_q;
  logic     err_q;

  logic req_hs, cmd_hs, w_hs, r_hs, rsp_hs;
  logic rd_beat, rd_done, rd_proto_err;
  word_t buf_rd_word;
  line_t buf_line;

  assign req_hs  = llc.llc_mem_req_valid && llc.llc_mem_req_ready;
  assign cmd_hs  = mem.mem_cmd_valid && mem.mem_cmd_ready;
  assign w_hs    = mem.mem_wdata_valid && mem.mem_wdata_ready;
  assign r_hs    = mem.mem_rdata_valid && mem.mem_rdata_ready;
  assign rsp_hs  = llc.llc_mem_rsp_valid && llc.llc_mem_rsp_ready;

  assign rd_beat      = (state_q == ST_RDATA) && r_hs;
  assign rd_done      = rd_beat && (mem.mem_rlast || cnt_q == LAST_IDX);
  assign rd_proto_err = rd_beat && (mem.mem_rlast != (cnt_q == LAST_IDX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_hs) state_d = ST_CMD;
      ST_CMD:   if (cmd_hs) state_d = cmd_q.write ? ST_WDATA : ST_RDATA;
      ST_WDATA: if (w_hs && cnt_q == LAST_IDX) state_d = ST_WACK;
      ST_WACK:  if (mem.mem_wack_valid) state_d = ST_IDLE;
      ST_RDATA: if (rd_done) state_d = ST_RSP;
      ST_RSP:   if (rsp_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are masked while rst is high so the reset values hold even in IDLE.
  always_comb begin
    llc.llc_mem_req_ready = 1'b0;
    llc.llc_mem_rsp_valid = 1'b0;
    mem.mem_cmd_valid     = 1'b0;
    mem.mem_wdata_valid   = 1'b0;
    mem.mem_wlast         = 1'b0;
    mem.mem_rdata_ready   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          llc.llc_mem_req_ready = 1'b1;
          mem.mem_rdata_ready   = 1'b1;
        end
        ST_CMD:   mem.mem_cmd_valid = 1'b1;
        ST_WDATA: begin
          mem.mem_wdata_valid = 1'b1;
          mem.mem_wlast       = (cnt_q == LAST_IDX);
        end
        ST_RDATA: mem.mem_rdata_ready = 1'b1;
        ST_RSP:   llc.llc_mem_rsp_valid = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (req_hs) begin
        cmd_q.write <= llc.llc_mem_req_data_hwrite;
        cmd_q.addr  <= line_to_byte_addr(llc.llc_mem_req_data_addr);
        cmd_q.len   <= LAST_IDX;
        cmd_q.size  <= llc.llc_mem_req_data_hsize;
        cmd_q.prot  <= llc.llc_mem_req_data_hprot;
      end
      // Early rlast must still leave the counter at 0 for the next burst.
      if (state_q == ST_CMD && cmd_hs) begin
        cnt_q <= '0;
      end else if (rd_done) begin
        cnt_q <= '0;
      end else if (w_hs || rd_beat) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((mem.mem_wack_valid && state_q != ST_WACK) || rd_proto_err ||
          (state_q == ST_IDLE && r_hs)) begin
        err_q <= 1'b1;
      end
    end
  end

  llc_mem_line_buf u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (req_hs),
    .load_line (llc.llc_mem_req_data_line),
    .clr       (state_q == ST_CMD && cmd_hs && !cmd_q.write),
    .wr_en     (rd_beat),
    .wr_idx    (cnt_q),
    .wr_word   (mem.mem_rdata),
    .rd_idx    (cnt_q),
    .rd_word   (buf_rd_word),
    .line      (buf_line)
  );

  assign mem.mem_cmd_write      = cmd_q.write;
  assign mem.mem_cmd_addr       = cmd_q.addr;
  assign mem.mem_cmd_len        = cmd_q.len;
  assign mem.mem_cmd_size       = cmd_q.size;
  assign mem.mem_cmd_prot       = cmd_q.prot;
  assign mem.mem_wdata          = buf_rd_word;
  assign llc.llc_mem_rsp_data_line = buf_line;
  assign err_sticky             = err_q;

endmodule

// File: tb/tb_llc_mem_bridge.sv
// tb/tb_llc_mem_bridge.sv - self-checking bench for llc_mem_bridge with a line-level reference model
module tb_llc_mem_bridge;
  import llc_mem_bridge_pkg::*;

  typedef logic [LINE_BITS-1:0] flat_t;

  logic clk = 1'b0;
  logic rst;
  logic err_sticky;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  llc_mem_if  llc ();
  mem_beat_if mem ();

  llc_mem_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .llc        (llc),
    .mem        (mem),
    .err_sticky (err_sticky)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // Reference model: byte address, expected fill line and expected write beats.
  function automatic addr_t model_addr(input line_addr_t a);
    return addr_t'(a) * addr_t'(LINE_BYTES);
  endfunction

  function automatic flat_t model_fill(input word_t beats[$]);
    flat_t v = '0;
    foreach (beats[i]) v = v | (flat_t'(beats[i]) << (i * BITS_PER_WORD));
    return v;
  endfunction

  function automatic word_t model_wbeat(input flat_t ln, input int i);
    return word_t'(ln >> (i * BITS_PER_WORD));
  endfunction

  function automatic word_t rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    llc.llc_mem_req_valid       = 1'b0;
    llc.llc_mem_req_data_hwrite = 1'b0;
    llc.llc_mem_req_data_hsize  = '0;
    llc.llc_mem_req_data_hprot  = '0;
    llc.llc_mem_req_data_addr   = '0;
    llc.llc_mem_req_data_line   = '0;
    llc.llc_mem_rsp_ready       = 1'b0;
    mem.mem_cmd_ready           = 1'b0;
    mem.mem_wdata_ready         = 1'b0;
    mem.mem_wack_valid          = 1'b0;
    mem.mem_rdata_valid         = 1'b0;
    mem.mem_rdata               = '0;
    mem.mem_rlast               = 1'b0;
  endtask

  task automatic send_req(input bit wr, input line_addr_t a, input hsize_t sz,
                          input hprot_t pr, input flat_t ln, output bit ok);
    llc.llc_mem_req_valid       = 1'b1;
    llc.llc_mem_req_data_hwrite = wr;
    llc.llc_mem_req_data_addr   = a;
    llc.llc_mem_req_data_hsize  = sz;
    llc.llc_mem_req_data_hprot  = pr;
    llc.llc_mem_req_data_line   = ln;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (llc.llc_mem_req_ready) ok = 1'b1;
      @(negedge clk);
    end
    llc.llc_mem_req_valid = 1'b0;
  endtask

  task automatic take_cmd(output mem_cmd_t c, output int waits, output bit ok);
    mem.mem_cmd_ready = 1'b1;
    ok = 1'b0; waits = 0; c = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem.mem_cmd_valid) begin
        ok = 1'b1;
        c.write = mem.mem_cmd_write; c.addr = mem.mem_cmd_addr; c.len = mem.mem_cmd_len;
        c.size  = mem.mem_cmd_size;  c.prot = mem.mem_cmd_prot;
      end else begin
        waits++;
      end
      @(negedge clk);
    end
    mem.mem_cmd_ready = 1'b0;
  endtask

  task automatic give_beats(input word_t beats[$], input int rlast_idx, output bit ok);
    ok = 1'b1;
    foreach (beats[i]) begin
      bit got = 1'b0;
      mem.mem_rdata_valid = 1'b1;
      mem.mem_rdata       = beats[i];
      mem.mem_rlast       = (i == rlast_idx);
      for (int k = 0; k < 20 && !got; k++) begin
        if (mem.mem_rdata_ready) got = 1'b1;
        @(negedge clk);
      end
      if (!got) ok = 1'b0;
    end
    mem.mem_rdata_valid = 1'b0;
    mem.mem_rlast       = 1'b0;
    mem.mem_rdata       = '0;
  endtask

  task automatic wait_rsp(output int cyc, output flat_t ln, output bit ok);
    ok = 1'b0; cyc = 0; ln = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc++;
      if (llc.llc_mem_rsp_valid) begin
        ok = 1'b1;
        ln = llc.llc_mem_rsp_data_line;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic take_rsp();
    llc.llc_mem_rsp_ready = 1'b1;
    @(negedge clk);
    llc.llc_mem_rsp_ready = 1'b0;
  endtask

  task automatic take_wbeats(input bit toggle, output word_t got[$], output bit lasts[$],
                             output bit saw_rsp, output bit ok);
    got = {}; lasts = {}; ok = 1'b0; saw_rsp = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      mem.mem_wdata_ready = toggle ? ((i % 2) == 1) : 1'b1;
      if (llc.llc_mem_rsp_valid) saw_rsp = 1'b1;
      if (mem.mem_wdata_valid && mem.mem_wdata_ready) begin
        got.push_back(mem.mem_wdata);
        lasts.push_back(mem.mem_wlast);
        if (got.size() == WORDS_PER_LINE) ok = 1'b1;
      end
      @(negedge clk);
    end
    mem.mem_wdata_ready = 1'b0;
  endtask

  task automatic pulse_wack();
    mem.mem_wack_valid = 1'b1;
    @(negedge clk);
    mem.mem_wack_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    total++;
    if ({llc.llc_mem_req_ready, llc.llc_mem_rsp_valid, mem.mem_cmd_valid, mem.mem_wdata_valid,
         mem.mem_wlast, mem.mem_rdata_ready, err_sticky} !== 7'b0) begin
      bad++; $display("FAIL reset_ctl: got %b need 0", {llc.llc_mem_req_ready,
        llc.llc_mem_rsp_valid, mem.mem_cmd_valid, mem.mem_wdata_valid, mem.mem_wlast,
        mem.mem_rdata_ready, err_sticky});
    end
    total++;
    if ({mem.mem_cmd_addr, mem.mem_cmd_len, mem.mem_wdata, llc.llc_mem_rsp_data_line} !== '0) begin
      bad++; $display("FAIL reset_data: got addr %h len %0d need 0", mem.mem_cmd_addr, mem.mem_cmd_len);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (llc.llc_mem_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b need 1", llc.llc_mem_req_ready);
    end
  endtask

  task automatic test_read_basic();
    word_t beats[$];
    mem_cmd_t c;
    int waits, cyc;
    bit ok;
    flat_t ln, exp;
    beats = {64'hA, 64'hB, 64'hC, 64'hD};
    exp = model_fill(beats);
    send_req(1'b0, 27'h1234, 3'd3, 2'd2, '0, ok);
    take_cmd(c, waits, ok);
    total++;
    if (!ok || waits != 0) begin
      bad++; $display("FAIL read_cmd_latency: got ok=%0d waits=%0d need ok=1 waits=0", ok, waits);
    end
    total++;
    if ({c.write, c.addr, c.len, c.size, c.prot} !==
        {1'b0, model_addr(27'h1234), cnt_t'(WORDS_PER_LINE - 1), 3'd3, 2'd2}) begin
      bad++; $display("FAIL read_cmd_fields: got w=%0d addr=%h len=%0d size=%0d prot=%0d need addr=%h",
                      c.write, c.addr, c.len, c.size, c.prot, model_addr(27'h1234));
    end
    give_beats(beats, 3, ok);
    wait_rsp(cyc, ln, ok);
    total++;
    if (!ok || cyc != 1) begin
      bad++; $display("FAIL read_rsp_latency: got ok=%0d cycles=%0d need 1", ok, cyc);
    end
    total++;
    if (ln !== exp) begin
      bad++; $display("FAIL read_line: got %h need %h", ln, exp);
    end
    take_rsp();
    total++;
    if (llc.llc_mem_rsp_valid !== 1'b0 || llc.llc_mem_req_ready !== 1'b1 || err_sticky !== 1'b0) begin
      bad++; $display("FAIL read_back_to_idle: got rsp_valid=%b req_ready=%b err=%b need 0 1 0",
                      llc.llc_mem_rsp_valid, llc.llc_mem_req_ready, err_sticky);
    end
  endtask

  task automatic test_write_toggle();
    word_t got[$];
    bit lasts[$];
    mem_cmd_t c;
    int waits;
    bit ok, saw_rsp;
    flat_t ln;
    ln = (flat_t'(4) << 192) | (flat_t'(3) << 128) | (flat_t'(2) << 64) | flat_t'(1);
    send_req(1'b1, 27'h0055, 3'd3, 2'd1, ln, ok);
    take_cmd(c, waits, ok);
    total++;
    if (!ok || c.write !== 1'b1 || c.addr !== model_addr(27'h0055)) begin
      bad++; $display("FAIL write_cmd: got ok=%0d w=%0d addr=%h need w=1 addr=%h",
                      ok, c.write, c.addr, model_addr(27'h0055));
    end
    take_wbeats(1'b1, got, lasts, saw_rsp, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL write_beat_count: got %0d beats need %0d", got.size(), WORDS_PER_LINE);
    end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== word_t'(i + 1) || lasts[i] !== (i == WORDS_PER_LINE - 1)) begin
        bad++; $display("FAIL write_beat%0d: got data=%h last=%0d need data=%h last=%0d",
                        i, got[i], lasts[i], word_t'(i + 1), (i == WORDS_PER_LINE - 1));
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (llc.llc_mem_req_ready !== 1'b0 || llc.llc_mem_rsp_valid !== 1'b0 || saw_rsp) begin
      bad++; $display("FAIL write_wait_wack: got req_ready=%b rsp_valid=%b saw_rsp=%0d need 0 0 0",
                      llc.llc_mem_req_ready, llc.llc_mem_rsp_valid, saw_rsp);
    end
    pulse_wack();
    total++;
    if (llc.llc_mem_req_ready !== 1'b1 || err_sticky !== 1'b0 || llc.llc_mem_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL write_after_wack: got req_ready=%b err=%b rsp_valid=%b need 1 0 0",
                      llc.llc_mem_req_ready, err_sticky, llc.llc_mem_rsp_valid);
    end
  endtask

  task automatic test_rsp_stall();
    word_t beats[$];
    mem_cmd_t c;
    int waits, cyc, unstable;
    bit ok;
    flat_t ln, exp;
    for (int i = 0; i < WORDS_PER_LINE; i++) beats.push_back(rand_word());
    exp = model_fill(beats);
    send_req(1'b0, line_addr_t'($urandom), 3'd2, 2'd0, '0, ok);
    take_cmd(c, waits, ok);
    give_beats(beats, WORDS_PER_LINE - 1, ok);
    wait_rsp(cyc, ln, ok);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (llc.llc_mem_rsp_valid !== 1'b1 || llc.llc_mem_rsp_data_line !== exp ||
          llc.llc_mem_req_ready !== 1'b0) unstable++;
      @(negedge clk);
    end
    total++;
    if (unstable != 0) begin
      bad++; $display("FAIL rsp_stall_hold: got %0d unstable cycles need 0", unstable);
    end
    total++;
    if (llc.llc_mem_rsp_data_line !== exp) begin
      bad++; $display("FAIL rsp_stall_line: got %h need %h", llc.llc_mem_rsp_data_line, exp);
    end
    take_rsp();
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      word_t beats[$], got[$];
      bit lasts[$];
      mem_cmd_t c;
      int waits, cyc;
      bit ok, saw_rsp, wr;
      flat_t ln, exp, wline;
      line_addr_t a;
      hsize_t sz;
      hprot_t pr;
      wr = $urandom_range(0, 1);
      a  = line_addr_t'($urandom);
      sz = hsize_t'($urandom_range(0, 7));
      pr = hprot_t'($urandom_range(0, 3));
      wline = '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) wline = (wline << BITS_PER_WORD) | flat_t'(rand_word());
      send_req(wr, a, sz, pr, wline, ok);
      take_cmd(c, waits, ok);
      total++;
      if (!ok || {c.write, c.addr, c.len, c.size, c.prot} !==
          {wr, model_addr(a), cnt_t'(WORDS_PER_LINE - 1), sz, pr}) begin
        bad++; $display("FAIL rand%0d_cmd: got w=%0d addr=%h size=%0d prot=%0d need w=%0d addr=%h size=%0d prot=%0d",
                        t, c.write, c.addr, c.size, c.prot, wr, model_addr(a), sz, pr);
      end
      if (wr) begin
        take_wbeats($urandom_range(0, 1), got, lasts, saw_rsp, ok);
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
          total++;
          if (!ok || got[i] !== model_wbeat(wline, i) || lasts[i] !== (i == WORDS_PER_LINE - 1)) begin
            bad++; $display("FAIL rand%0d_wbeat%0d: got ok=%0d need data=%h", t, i, ok, model_wbeat(wline, i));
          end
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        pulse_wack();
      end else begin
        beats = {};
        for (int i = 0; i < WORDS_PER_LINE; i++) beats.push_back(rand_word());
        exp = model_fill(beats);
        give_beats(beats, WORDS_PER_LINE - 1, ok);
        wait_rsp(cyc, ln, ok);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        total++;
        if (!ok || llc.llc_mem_rsp_data_line !== exp) begin
          bad++; $display("FAIL rand%0d_line: got %h need %h", t, llc.llc_mem_rsp_data_line, exp);
        end
        take_rsp();
      end
    end
    total++;
    if (err_sticky !== 1'b0) begin
      bad++; $display("FAIL rand_no_err: got err=%b need 0", err_sticky);
    end
  endtask

  task automatic test_early_rlast();
    word_t beats[$];
    mem_cmd_t c;
    int waits, cyc;
    bit ok;
    flat_t ln, exp;
    beats = {64'h7, 64'h8};
    exp = model_fill(beats);
    send_req(1'b0, 27'h0777, 3'd3, 2'd3, '1, ok);
    take_cmd(c, waits, ok);
    give_beats(beats, 1, ok);
    wait_rsp(cyc, ln, ok);
    total++;
    if (!ok || cyc != 1 || ln !== exp) begin
      bad++; $display("FAIL early_rlast_line: got ok=%0d cycles=%0d line=%h need line=%h", ok, cyc, ln, exp);
    end
    total++;
    if (err_sticky !== 1'b1) begin
      bad++; $display("FAIL early_rlast_err: got %b need 1", err_sticky);
    end
    take_rsp();
  endtask

  task automatic test_reset_mid();
    word_t beats[$], one[$];
    mem_cmd_t c;
    int waits, cyc;
    bit ok;
    flat_t ln, exp;
    send_req(1'b0, 27'h0ABC, 3'd3, 2'd0, '0, ok);
    take_cmd(c, waits, ok);
    one = {64'hDEAD};
    give_beats(one, -1, ok);
    mem.mem_rdata_valid = 1'b1;
    mem.mem_rdata       = 64'hBEEF;
    rst = 1'b1;
    #1;
    total++;
    if ({llc.llc_mem_req_ready, llc.llc_mem_rsp_valid, mem.mem_cmd_valid, mem.mem_wdata_valid,
         mem.mem_rdata_ready, err_sticky, mem.mem_cmd_addr, llc.llc_mem_rsp_data_line} !== '0) begin
      bad++; $display("FAIL reset_mid_outputs: got req_ready=%b rdata_ready=%b err=%b addr=%h need all 0",
                      llc.llc_mem_req_ready, mem.mem_rdata_ready, err_sticky, mem.mem_cmd_addr);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < WORDS_PER_LINE; i++) beats.push_back(rand_word());
    exp = model_fill(beats);
    send_req(1'b0, 27'h0ABD, 3'd1, 2'd1, '0, ok);
    take_cmd(c, waits, ok);
    total++;
    if (!ok || c.addr !== model_addr(27'h0ABD) || waits != 0) begin
      bad++; $display("FAIL reset_mid_cmd: got ok=%0d addr=%h waits=%0d need addr=%h",
                      ok, c.addr, waits, model_addr(27'h0ABD));
    end
    give_beats(beats, WORDS_PER_LINE - 1, ok);
    wait_rsp(cyc, ln, ok);
    total++;
    if (!ok || ln !== exp || err_sticky !== 1'b0) begin
      bad++; $display("FAIL reset_mid_read: got line=%h err=%b need line=%h err=0", ln, err_sticky, exp);
    end
    take_rsp();
  endtask

  task automatic test_stray_wack();
    total++;
    if (err_sticky !== 1'b0 || llc.llc_mem_req_ready !== 1'b1) begin
      bad++; $display("FAIL stray_wack_pre: got err=%b req_ready=%b need 0 1", err_sticky, llc.llc_mem_req_ready);
    end
    pulse_wack();
    total++;
    if (err_sticky !== 1'b1 || llc.llc_mem_req_ready !== 1'b1 || mem.mem_cmd_valid !== 1'b0) begin
      bad++; $display("FAIL stray_wack: got err=%b req_ready=%b cmd_valid=%b need 1 1 0",
                      err_sticky, llc.llc_mem_req_ready, mem.mem_cmd_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_read_basic();
    test_write_toggle();
    test_rsp_stall();
    test_random();
    test_early_rlast();
    test_reset_mid();
    test_stray_wack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
